ihadamard4x4_stream: RTL and testbench
======================================

# ihadamard4x4_stream

Streaming 4x4 inverse Hadamard transform for the FME/reconstruction path. It is the decode-side counterpart of the forward Hadamard used for SATD distortion: it accepts a block of transform coefficients one row per beat and returns the reconstructed residual one row per beat. It applies the same 4-point butterfly on rows, then columns, then rounds and scales by 1/16 (H·H = 4I). It has double banking, so loading of block n+1 overlaps with draining of block n.

## Interface
- IN_W, 14, signed coefficient width
- OUT_W, 9, signed residual width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when in_valid && in_ready
- in_row  in  4*IN_W  coefficients x0..x3, x0 in LSBs, two's complement
- out_valid  out  1  output row valid
- out_ready  in  1  output row consumed when out_valid && out_ready
- out_row  out  4*OUT_W  residuals y0..y3, y0 in LSBs
- out_first  out  1  high with row 0 of each block
- out_last  out  1  high with row 3 of each block

## Operation
- 1D butterfly f(a,b,c,d):
  - s0 = a+d, s1 = b+c, d0 = a-d, d1 = b-c
  - outputs: s0+s1, d1+d0, s0-s1, d0-d1
- Row stage:
  - Applied combinationally to each accepted in_row.
  - Result (IN_W+2 bits, sign-extended, no overflow) is written to load bank row ld_cnt.
- Load side FSM: LOAD(ld_cnt 0..3) -> FULL.
  - LOAD: in_ready=1. Each handshake writes the row and increments ld_cnt. The handshake at ld_cnt=3 moves to FULL.
  - FULL: in_ready=0.
- Transfer (single cycle):
  - Occurs when the load side is FULL and the output bank is free. Free means EMPTY, or the row-3 out handshake is occurring in the same cycle.
  - Applies f() to each of the 4 columns of the load bank (IN_W+4 bits).
  - Rounds each value v: r = (v + 8) >>> 4 (arithmetic).
  - Writes r to the output bank. The load side returns to LOAD with ld_cnt=0.
- Output side FSM: EMPTY -> EMIT(out_cnt 0..3) -> EMPTY, or straight back to EMIT(0) on a simultaneous transfer.
  - out_valid=1 in EMIT. out_row = output bank row out_cnt.
  - out_first = (out_cnt==0), out_last = (out_cnt==3).
  - out_cnt increments only on handshake. out_row is held stable while out_valid && !out_ready.
- Rows are never dropped or duplicated. in_row is ignored when !in_ready.
- Reset values:
  - in_ready=1, out_valid=0, out_first=0, out_last=0, out_row=0.
  - ld_cnt=0, out_cnt=0, both banks cleared.
- Reset mid-block discards all partial and pending data. There is no output after reset until 4 new rows have been loaded.

## Timing
- Latency: row-3 input handshake at edge E; transfer in the following cycle; out_valid=1 with row 0 two cycles after E.
- Sustained throughput with out_ready=1: one block per 5 cycles. That is 4 load beats plus 1 FULL/transfer cycle; drain fully overlaps the next load.
- Backpressure: if out_ready stays low, the load side fills the second block and stalls in FULL (in_ready=0) until the last output row is consumed.
- in_ready depends only on registered state, not combinationally on out_ready.

## Configuration
- IHAD_SAT_EN defined:
  - r is clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] before storage.
- IHAD_SAT_EN undefined:
  - r is truncated to its OUT_W LSBs (wrap-around).
  - Saves comparators when the upstream guarantees range.

## Test plan
- DC block, in_row0={x0=16, others 0}, rows1-3 zero -> all 16 outputs = 1. out_first on row 0, out_last on row 3, first out_valid 2 cycles after the row-3 handshake.
- Rounding: x00=8 -> all outputs 1; x00=-8 -> all outputs 0; x00=-9 -> all outputs -1.
- Round trip: random 9-bit residuals through a reference forward 2D Hadamard, fed in -> exact original residuals. Run 1000 blocks back-to-back with in_valid=1 and out_ready=1 -> one block per 5 cycles.
- Saturation: x00=4800. With IHAD_SAT_EN -> all outputs 255; without -> all outputs -212.
- Backpressure: hold out_ready=0 for 20 cycles while streaming -> in_ready drops after block 2 is loaded, out_row is stable, no loss or duplication once released. Also toggle out_ready randomly.
- Async reset asserted mid-load (after row 2) and mid-drain (after output row 1) -> outputs immediately take their reset values. The next 4 rows produce a correct fresh block with no residue from the old one.

Source files
------------

// File: rtl/ihadamard4x4_stream_if.sv
// rtl/ihadamard4x4_stream_if.sv - row-stream handshake bundle for the 4x4 inverse Hadamard
// Coefficient rows flow in, residual rows flow out; DUT side is the slave modport.
interface ihadamard4x4_stream_if #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 9
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4*IN_W-1:0]    in_row;
  logic                 out_valid;
  logic                 out_ready;
  logic [4*OUT_W-1:0]   out_row;
  logic                 out_first;
  logic                 out_last;

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_row, out_first, out_last
  );

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_row, out_first, out_last
  );
endinterface

// File: rtl/ihadamard4x4_stream.sv
// rtl/ihadamard4x4_stream.sv - streaming 4x4 inverse Hadamard, row then column butterfly, /16 rounding
// Double-banked load/drain; define IHAD_SAT_EN to clip results instead of wrapping to OUT_W bits.
module ihadamard4x4_stream #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 9
) (
  input logic                  clk,
  input logic                  rst,
  ihadamard4x4_stream_if.slave s
);
  localparam int RW = IN_W + 2;
  localparam int CW = IN_W + 4;
`ifdef IHAD_SAT_EN
  localparam logic signed [CW:0] MAX_R = (CW+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [CW:0] MIN_R = -(CW+1)'(2**(OUT_W-1));
`endif

  typedef enum logic {LD_LOAD, LD_FULL} ld_state_t;
  typedef enum logic {OUT_EMPTY, OUT_EMIT} out_state_t;

  function automatic logic signed [CW-1:0] bfly(input logic signed [CW-1:0] a, b, c, d,
                                                input int k);
    logic signed [CW-1:0] s0, s1, d0, d1;
    s0 = a + d;
    s1 = b + c;
    d0 = a - d;
    d1 = b - c;
    case (k)
      0:       bfly = s0 + s1;
      1:       bfly = d1 + d0;
      2:       bfly = s0 - s1;
      default: bfly = d0 - d1;
    endcase
  endfunction

  function automatic logic signed [OUT_W-1:0] rnd(input logic signed [CW-1:0] v);
    logic signed [CW:0] t;
    t = ((CW+1)'(v) + (CW+1)'(8)) >>> 4;
`ifdef IHAD_SAT_EN
    if (t > MAX_R)      rnd = OUT_W'(MAX_R);
    else if (t < MIN_R) rnd = OUT_W'(MIN_R);
    else                rnd = OUT_W'(t);
`else
    rnd = OUT_W'(t);
`endif
  endfunction

  ld_state_t              r_ld_state, w_ld_next;
  out_state_t             r_out_state, w_out_next;
  logic [1:0]             r_ld_cnt, r_out_cnt;
  logic signed [RW-1:0]   r_ld_bank  [4][4];
  logic signed [OUT_W-1:0] r_out_bank [4][4];
  logic signed [IN_W-1:0] w_x   [4];
  logic signed [RW-1:0]   w_row [4];
  logic signed [OUT_W-1:0] w_res [4][4];
  logic                   w_in_fire, w_out_fire, w_xfer;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_x[k]   = $signed(s.in_row[k*IN_W +: IN_W]);
    end
    for (int k = 0; k < 4; k++) begin
      w_row[k] = RW'(bfly(CW'(w_x[0]), CW'(w_x[1]), CW'(w_x[2]), CW'(w_x[3]), k));
    end
  end

  // Column butterfly reads the full load bank; r indexes output row, k the column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        w_res[r][k] = rnd(bfly(CW'(r_ld_bank[0][k]), CW'(r_ld_bank[1][k]),
                               CW'(r_ld_bank[2][k]), CW'(r_ld_bank[3][k]), r));
      end
    end
  end

  assign w_in_fire  = s.in_valid && (r_ld_state == LD_LOAD);
  assign w_out_fire = s.out_ready && (r_out_state == OUT_EMIT);
  // The output bank is free when empty or when its last row leaves this very cycle.
  assign w_xfer     = (r_ld_state == LD_FULL) &&
                      ((r_out_state == OUT_EMPTY) || (w_out_fire && r_out_cnt == 2'd3));

  always_comb begin
    w_ld_next  = r_ld_state;
    w_out_next = r_out_state;
    case (r_ld_state)
      LD_LOAD: if (w_in_fire && r_ld_cnt == 2'd3) w_ld_next = LD_FULL;
      default: if (w_xfer) w_ld_next = LD_LOAD;
    endcase
    case (r_out_state)
      OUT_EMPTY: if (w_xfer) w_out_next = OUT_EMIT;
      default:   if (w_out_fire && r_out_cnt == 2'd3) w_out_next = w_xfer ? OUT_EMIT : OUT_EMPTY;
    endcase
    s.in_ready  = (r_ld_state == LD_LOAD);
    s.out_valid = (r_out_state == OUT_EMIT);
    s.out_first = (r_out_state == OUT_EMIT) && (r_out_cnt == 2'd0);
    s.out_last  = (r_out_state == OUT_EMIT) && (r_out_cnt == 2'd3);
    s.out_row   = '0;
    if (r_out_state == OUT_EMIT) begin
      for (int k = 0; k < 4; k++) begin
        s.out_row[k*OUT_W +: OUT_W] = r_out_bank[r_out_cnt][k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_state  <= LD_LOAD;
      r_out_state <= OUT_EMPTY;
      r_ld_cnt    <= 2'd0;
      r_out_cnt   <= 2'd0;
      for (int r = 0; r < 4; r++) begin
        for (int k = 0; k < 4; k++) begin
          r_ld_bank[r][k]  <= '0;
          r_out_bank[r][k] <= '0;
        end
      end
    end else begin
      r_ld_state  <= w_ld_next;
      r_out_state <= w_out_next;
      if (w_xfer)         r_ld_cnt <= 2'd0;
      else if (w_in_fire) r_ld_cnt <= r_ld_cnt + 2'd1;
      if (w_out_fire)     r_out_cnt <= r_out_cnt + 2'd1;
      if (w_in_fire) begin
        for (int k = 0; k < 4; k++) r_ld_bank[r_ld_cnt][k] <= w_row[k];
      end
      if (w_xfer) r_out_bank <= w_res;
    end
  end
endmodule

// File: tb/tb_ihadamard4x4_stream.sv
// tb/tb_ihadamard4x4_stream.sv - randomized self-checking bench for ihadamard4x4_stream
// Expected residuals come from matrix arithmetic H*C*H/16 on plain ints.
module tb_ihadamard4x4_stream;
  localparam int IN_W  = 14;
  localparam int OUT_W = 9;
  localparam int OR_W  = 4*OUT_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ihadamard4x4_stream_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus();
  ihadamard4x4_stream #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (.clk(clk), .rst(rst), .s(bus));

  int checks = 0;
  int errors = 0;
  int hm [4][4] = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};

  logic [4*IN_W-1:0] in_q  [$];
  logic [OR_W-1:0]   exp_q [$];
  logic [OR_W+1:0]   cap_q [$];
  int first_in, last_in, first_valid, stable_viol, timed_out, hold_acc;
  logic hold_rdy;

  function automatic int fit(input int r);
    int t;
`ifdef IHAD_SAT_EN
    t = (r > 255) ? 255 : (r < -256) ? -256 : r;
`else
    t = r & 511;
    if (t >= 256) t = t - 512;
`endif
    return t;
  endfunction

  task automatic mul3(input int a [4][4], output int y [4][4]);
    int t [4][4];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        t[i][j] = 0;
        for (int k = 0; k < 4; k++) t[i][j] += hm[i][k] * a[k][j];
      end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        y[i][j] = 0;
        for (int k = 0; k < 4; k++) y[i][j] += t[i][k] * hm[k][j];
      end
  endtask

  task automatic add_rows(input int c [4][4]);
    logic [4*IN_W-1:0] row;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) row[j*IN_W +: IN_W] = IN_W'(c[i][j]);
      in_q.push_back(row);
    end
  endtask

  task automatic add_exp(input int x [4][4]);
    logic [OR_W-1:0] row;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) row[j*OUT_W +: OUT_W] = OUT_W'(x[i][j]);
      exp_q.push_back(row);
    end
  endtask

  task automatic add_model(input int c [4][4]);
    int v [4][4];
    mul3(c, v);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) v[i][j] = fit((v[i][j] + 8) >>> 4);
    add_exp(v);
  endtask

  task automatic add_const(input int x00, input int res);
    int c [4][4];
    int e [4][4];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        c[i][j] = 0;
        e[i][j] = res;
      end
    c[0][0] = x00;
    add_rows(c);
    add_exp(e);
  endtask

  task automatic rand_coefs(output int c [4][4]);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) c[i][j] = int'($urandom_range(0, 16383)) - 8192;
  endtask

  task automatic clear_q();
    in_q.delete();
    exp_q.delete();
    cap_q.delete();
  endtask

  // mode 0: out_ready high, 1: random out_ready, 2: out_ready low for 20 cycles then high
  task automatic run_stream(input int mode, input int gap_pct, input int stop_in,
                            input int stop_out, input int max_cyc);
    int cyc = 0;
    int n_in = 0;
    logic stalled = 1'b0;
    logic [OR_W-1:0] prev_row = '0;
    bit done;
    first_in = -1; last_in = -1; first_valid = -1;
    stable_viol = 0; timed_out = 0; hold_acc = -1; hold_rdy = 1'bx;
    while (1) begin
      @(negedge clk);
      if (stop_in >= 0)       done = (n_in >= stop_in);
      else if (stop_out >= 0) done = (cap_q.size() >= stop_out);
      else                    done = (cap_q.size() >= exp_q.size());
      if (done) break;
      if (cyc >= max_cyc) begin
        timed_out = 1;
        break;
      end
      if (mode == 2 && cyc == 20) begin
        hold_acc = n_in;
        hold_rdy = bus.in_ready;
      end
      bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : (cyc >= 20);
      if (stalled && (!bus.out_valid || bus.out_row !== prev_row)) stable_viol++;
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (in_q.size() > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
        bus.in_valid = 1'b1;
        bus.in_row   = in_q[0];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_row   = {$urandom, $urandom};
      end
      if (bus.in_valid && bus.in_ready) begin
        void'(in_q.pop_front());
        n_in++;
        if (first_in < 0) first_in = cyc;
        last_in = cyc;
      end
      if (bus.out_valid && bus.out_ready) cap_q.push_back({bus.out_last, bus.out_first, bus.out_row});
      stalled  = bus.out_valid && !bus.out_ready;
      prev_row = bus.out_row;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_row = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_first, bus.out_last} !== 4'b1000 || bus.out_row !== '0) begin
      errors++;
      $display("FAIL reset_hold rdy/vld/first/last=%b row=%h exp 1000 row 0",
               {bus.in_ready, bus.out_valid, bus.out_first, bus.out_last}, bus.out_row);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_first, bus.out_last} !== 4'b1000 || bus.out_row !== '0) begin
      errors++;
      $display("FAIL reset_release rdy/vld/first/last=%b row=%h exp 1000 row 0",
               {bus.in_ready, bus.out_valid, bus.out_first, bus.out_last}, bus.out_row);
    end
  endtask

  task automatic test_dc();
    clear_q();
    add_const(16, 1);
    run_stream(0, 0, -1, -1, 100);
    checks++;
    if (timed_out != 0 || cap_q.size() != 4) begin
      errors++;
      $display("FAIL dc_count got %0d rows timeout=%0d exp 4", cap_q.size(), timed_out);
    end
    checks++;
    if (first_valid - last_in != 2) begin
      errors++;
      $display("FAIL dc_latency got %0d cycles exp 2", first_valid - last_in);
    end
    for (int i = 0; i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== {1'(i == 3), 1'(i == 0), exp_q[i]}) begin
        errors++;
        $display("FAIL dc_row%0d got %h exp %h", i, cap_q[i], {1'(i == 3), 1'(i == 0), exp_q[i]});
      end
    end
  endtask

  task automatic test_rounding();
    clear_q();
    add_const(8, 1);
    add_const(-8, 0);
    add_const(-9, -1);
    run_stream(0, 0, -1, -1, 200);
    checks++;
    if (timed_out != 0 || cap_q.size() != 12) begin
      errors++;
      $display("FAIL round_count got %0d rows exp 12", cap_q.size());
    end
    for (int i = 0; i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i][OR_W-1:0] !== exp_q[i]) begin
        errors++;
        $display("FAIL round_row%0d got %h exp %h", i, cap_q[i][OR_W-1:0], exp_q[i]);
      end
    end
  endtask

  task automatic test_saturation();
    clear_q();
`ifdef IHAD_SAT_EN
    add_const(4800, 255);
`else
    add_const(4800, -212);
`endif
    run_stream(0, 0, -1, -1, 100);
    checks++;
    if (timed_out != 0 || cap_q.size() != 4) begin
      errors++;
      $display("FAIL sat_count got %0d rows exp 4", cap_q.size());
    end
    for (int i = 0; i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i][OR_W-1:0] !== exp_q[i]) begin
        errors++;
        $display("FAIL sat_row%0d got %h exp %h", i, cap_q[i][OR_W-1:0], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int x [4][4];
    int y [4][4];
    clear_q();
    for (int b = 0; b < 1000; b++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) x[i][j] = int'($urandom_range(0, 511)) - 256;
      mul3(x, y);
      add_rows(y);
      add_exp(x);
    end
    run_stream(0, 0, -1, -1, 6000);
    checks++;
    if (timed_out != 0 || cap_q.size() != 4000) begin
      errors++;
      $display("FAIL b2b_count got %0d rows exp 4000", cap_q.size());
    end
    checks++;
    if (last_in - first_in != 4998) begin
      errors++;
      $display("FAIL b2b_throughput got %0d cycles exp 4998", last_in - first_in);
    end
    for (int i = 0; i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== {1'(i % 4 == 3), 1'(i % 4 == 0), exp_q[i]}) begin
        errors++;
        $display("FAIL b2b_row%0d got %h exp %h", i, cap_q[i], {1'(i % 4 == 3), 1'(i % 4 == 0), exp_q[i]});
      end
    end
  endtask

  task automatic test_backpressure();
    int c [4][4];
    clear_q();
    for (int b = 0; b < 3; b++) begin
      rand_coefs(c);
      add_rows(c);
      add_model(c);
    end
    run_stream(2, 0, -1, -1, 300);
    checks++;
    if (hold_acc != 8 || hold_rdy !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall accepted=%0d in_ready=%b exp 8 and 0", hold_acc, hold_rdy);
    end
    checks++;
    if (stable_viol != 0) begin
      errors++;
      $display("FAIL bp_stable got %0d changes exp 0", stable_viol);
    end
    checks++;
    if (timed_out != 0 || cap_q.size() != 12) begin
      errors++;
      $display("FAIL bp_count got %0d rows exp 12", cap_q.size());
    end
    for (int i = 0; i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i][OR_W-1:0] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_row%0d got %h exp %h", i, cap_q[i][OR_W-1:0], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_ready();
    int c [4][4];
    clear_q();
    for (int b = 0; b < 20; b++) begin
      rand_coefs(c);
      add_rows(c);
      add_model(c);
    end
    run_stream(1, 30, -1, -1, 3000);
    checks++;
    if (timed_out != 0 || cap_q.size() != 80 || stable_viol != 0) begin
      errors++;
      $display("FAIL rr_count got %0d rows %0d changes exp 80 rows 0 changes", cap_q.size(), stable_viol);
    end
    for (int i = 0; i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== {1'(i % 4 == 3), 1'(i % 4 == 0), exp_q[i]}) begin
        errors++;
        $display("FAIL rr_row%0d got %h exp %h", i, cap_q[i], {1'(i % 4 == 3), 1'(i % 4 == 0), exp_q[i]});
      end
    end
  endtask

  task automatic test_async_reset();
    int c [4][4];
    for (int phase = 0; phase < 2; phase++) begin
      clear_q();
      rand_coefs(c);
      add_rows(c);
      add_model(c);
      if (phase == 0) run_stream(0, 0, 3, -1, 100);
      else            run_stream(0, 0, -1, 2, 100);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.out_first, bus.out_last} !== 4'b1000 || bus.out_row !== '0) begin
        errors++;
        $display("FAIL arst%0d_now rdy/vld/first/last=%b row=%h exp 1000 row 0", phase,
                 {bus.in_ready, bus.out_valid, bus.out_first, bus.out_last}, bus.out_row);
      end
      @(negedge clk);
      rst = 1'b0;
      clear_q();
      rand_coefs(c);
      add_rows(c);
      add_model(c);
      run_stream(0, 0, -1, -1, 100);
      repeat (4) @(negedge clk);
      checks++;
      if (timed_out != 0 || cap_q.size() != 4 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL arst%0d_count got %0d rows valid=%b exp 4 rows valid 0", phase, cap_q.size(), bus.out_valid);
      end
      for (int i = 0; i < cap_q.size(); i++) begin
        checks++;
        if (cap_q[i] !== {1'(i == 3), 1'(i == 0), exp_q[i]}) begin
          errors++;
          $display("FAIL arst%0d_row%0d got %h exp %h", phase, i, cap_q[i], {1'(i == 3), 1'(i == 0), exp_q[i]});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_dc();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_random_ready();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
